pc_sequencer: RTL

Program-counter and control-flow sequencer for the 16-bit CPU, sitting directly downstream of the jump-condition comparator. Each enabled cycle it consumes the comparator's `jump` bit together with the decoded control-flow flags and the branch target. It then selects the next instruction address. It holds a small hardware return-address stack for call/return. It reports a one-cycle redirect pulse so fetch/decode can discard a wrong-path instruction.

---
 rtl/pc_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch address from return / call / branch / sequential
// sources and keeps a small hardware return-address stack for call/return.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        jump,
    input  logic        is_branch,
    input  logic        is_call,
    input  logic        is_ret,
    input  logic [15:0] target,
    output logic [15:0] pc,
    output logic        redirect,
    output logic [4:0]  depth,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int         PW   = $clog2(STACK_DEPTH);
    localparam logic [4:0] FULL = 5'(STACK_DEPTH);

    logic [15:0]   stack_mem [STACK_DEPTH];
    logic [15:0]   pc_inc;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;

    logic [15:0] pc_next;
    logic        redirect_next;
    logic [4:0]  depth_next;
    logic        ovf_next;
    logic        unf_next;
    logic        push;

    assign pc_inc = pc + 16'd1;
    // Slots are indexed by depth, so truncation keeps every index inside the array.
    assign wr_idx = depth[PW-1:0];
    assign rd_idx = PW'(depth - 5'd1);

    always_comb begin
        pc_next       = pc;
        redirect_next = 1'b0;
        depth_next    = depth;
        ovf_next      = stack_overflow;
        unf_next      = stack_underflow;
        push          = 1'b0;
        if (enable) begin
            if (is_ret) begin
                if (depth != 5'd0) begin
                    pc_next       = stack_mem[rd_idx];
                    depth_next    = depth - 5'd1;
                    redirect_next = 1'b1;
                end else begin
                    pc_next  = pc_inc;
                    unf_next = 1'b1;
                end
            end else if (is_call) begin
                pc_next       = target;
                redirect_next = 1'b1;
                if (depth == FULL) begin
                    ovf_next = 1'b1;
                end else begin
                    push       = 1'b1;
                    depth_next = depth + 5'd1;
                end
            end else if (is_branch && jump) begin
                pc_next       = target;
                redirect_next = 1'b1;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc              <= RESET_PC;
            redirect        <= 1'b0;
            depth           <= 5'd0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            pc              <= pc_next;
            redirect        <= redirect_next;
            depth           <= depth_next;
            stack_overflow  <= ovf_next;
            stack_underflow <= unf_next;
        end
    end

    // Stack storage needs no reset; a push coinciding with reset is suppressed.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

endmodule
